// File: rtl/seg_scan_rx_pkg.sv
// Shared constants for the scanned 7-segment receiver: segment codes, nibble codes, FSM states.
// Segment bit order is {a,b,c,d,e,f,g}, active-high.
package seg_scan_rx_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int SAMPLE_W   = NUM_DIGITS + 7 + 1;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h73;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] NIB_BLANK = 4'hF;
  localparam logic [3:0] NIB_ERR   = 4'hE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ENB_NONE  = 2'd0,
    ENB_ONE   = 2'd1,
    ENB_MULTI = 2'd2
  } enb_class_t;

  // Enables are active-low: count how many digits are selected at once.
  function automatic enb_class_t classifyEnb(input logic [NUM_DIGITS-1:0] enb);
    logic [NUM_DIGITS-1:0] sel;
    sel = ~enb;
    if (sel == '0)
      return ENB_NONE;
    else if ((sel & (sel - NUM_DIGITS'(1))) == '0)
      return ENB_ONE;
    else
      return ENB_MULTI;
  endfunction

endpackage

// File: rtl/seg_scan_rx_dec.sv
// seg_dec: combinational 7-segment pattern to nibble decoder.
// Blank decodes to NIB_BLANK without error; unknown patterns give NIB_ERR with o_invalid set.
module seg_dec
  import seg_scan_rx_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_nib,
  output logic       o_invalid
);

  always_comb begin
    o_nib     = NIB_ERR;
    o_invalid = 1'b0;
    case (i_seg)
      SEG_0:     o_nib = 4'd0;
      SEG_1:     o_nib = 4'd1;
      SEG_2:     o_nib = 4'd2;
      SEG_3:     o_nib = 4'd3;
      SEG_4:     o_nib = 4'd4;
      SEG_5:     o_nib = 4'd5;
      SEG_6:     o_nib = 4'd6;
      SEG_7:     o_nib = 4'd7;
      SEG_8:     o_nib = 4'd8;
      SEG_9:     o_nib = 4'd9;
      SEG_BLANK: o_nib = NIB_BLANK;
      default:   o_invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_rx.sv
// Receive end of a six-digit scanned 7-segment bus: filters each dwell, decodes it and publishes whole frames.
// Optional macro SEG_SYNC_EN adds a two-flop synchronizer on the bus inputs (+2 clocks latency).
module seg_scan_rx
  import seg_scan_rx_pkg::*;
#(
  parameter int STABLE_CNT = 4,
  parameter int TIMEOUT    = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  i_seg_enb,
  input  logic [6:0]  i_seg,
  input  logic        i_seg_dp,
  input  logic        i_clr,
  output logic [23:0] o_digits,
  output logic [5:0]  o_dp,
  output logic        o_frame_vld,
  output logic        o_err,
  output logic        o_scan_lost
);

  localparam int               CNT_W       = $clog2(STABLE_CNT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STABLE_CNT - 1);
  localparam logic [31:0]      TIMEOUT_VAL = 32'(TIMEOUT);

  logic [SAMPLE_W-1:0]   w_raw;
  logic [SAMPLE_W-1:0]   w_busIn;
  logic [SAMPLE_W-1:0]   r_s;
  logic [SAMPLE_W-1:0]   r_sPrev;
  logic                  w_change;
  logic [NUM_DIGITS-1:0] w_enb;
  logic [NUM_DIGITS-1:0] w_sel;
  logic [6:0]            w_seg;
  logic                  w_dp;

  state_t                r_state;
  state_t                w_stateNext;
  logic [CNT_W-1:0]      r_stabCnt;
  logic [CNT_W-1:0]      w_stabCntNext;
  logic                  w_latch;

  enb_class_t            w_class;
  logic [3:0]            w_nib;
  logic                  w_invalid;
  logic                  w_latchOne;
  logic                  w_errSet;
  logic                  w_publish;
  logic                  w_toHit;

  logic [23:0]           r_shadow;
  logic [NUM_DIGITS-1:0] r_shadowDp;
  logic [NUM_DIGITS-1:0] r_seen;
  logic [23:0]           r_digits;
  logic [NUM_DIGITS-1:0] r_dp;
  logic                  r_frameVld;
  logic                  r_err;
  logic                  r_scanLost;
  logic [31:0]           r_toCnt;

  assign w_raw = {i_seg_enb, i_seg, i_seg_dp};

`ifdef SEG_SYNC_EN
  logic [SAMPLE_W-1:0] r_sync1;
  logic [SAMPLE_W-1:0] r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_busIn = r_sync2;
`else
  assign w_busIn = w_raw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s     <= '0;
      r_sPrev <= '0;
    end else begin
      r_s     <= w_busIn;
      r_sPrev <= r_s;
    end
  end

  assign w_change = (r_s != r_sPrev);
  assign w_enb    = r_s[SAMPLE_W-1 -: NUM_DIGITS];
  assign w_seg    = r_s[7:1];
  assign w_dp     = r_s[0];
  assign w_sel    = ~w_enb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_stabCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_stabCnt <= w_stabCntNext;
    end
  end

  // One latch per dwell: HELD ignores the bus until the sampled pattern moves again.
  always_comb begin
    w_stateNext   = r_state;
    w_stabCntNext = r_stabCnt;
    w_latch       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_change) begin
          w_stateNext   = SETTLE;
          w_stabCntNext = '0;
        end
      end
      SETTLE: begin
        if (w_change) begin
          w_stabCntNext = '0;
        end else if (r_stabCnt == CNT_LAST) begin
          w_latch       = 1'b1;
          w_stateNext   = HELD;
          w_stabCntNext = '0;
        end else begin
          w_stabCntNext = r_stabCnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (w_change) begin
          w_stateNext   = SETTLE;
          w_stabCntNext = '0;
        end
      end
      default: begin
        w_stateNext   = IDLE;
        w_stabCntNext = '0;
      end
    endcase
  end

  seg_dec u_dec (
    .i_seg     (w_seg),
    .o_nib     (w_nib),
    .o_invalid (w_invalid)
  );

  assign w_class    = classifyEnb(w_enb);
  assign w_latchOne = w_latch && (w_class == ENB_ONE);
  assign w_errSet   = w_latch && ((w_class == ENB_MULTI) || ((w_class == ENB_ONE) && w_invalid));
  assign w_publish  = (r_seen == '1);
  assign w_toHit    = !w_latchOne && (r_toCnt == TIMEOUT_VAL - 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow   <= {NUM_DIGITS{NIB_BLANK}};
      r_shadowDp <= '0;
      r_seen     <= '0;
      r_digits   <= {NUM_DIGITS{NIB_BLANK}};
      r_dp       <= '0;
      r_frameVld <= 1'b0;
    end else begin
      r_frameVld <= w_publish;
      if (w_publish) begin
        r_digits <= r_shadow;
        r_dp     <= r_shadowDp;
      end
      if (w_publish || w_toHit)
        r_seen <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (w_latchOne && w_sel[k]) begin
          r_shadow[4*k +: 4] <= w_nib;
          r_shadowDp[k]      <= w_dp;
          r_seen[k]          <= 1'b1;
        end
      end
    end
  end

  // A new error outranks a clear arriving in the same clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_err <= 1'b0;
    else if (w_errSet)
      r_err <= 1'b1;
    else if (i_clr)
      r_err <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_toCnt    <= '0;
      r_scanLost <= 1'b0;
    end else if (w_latchOne) begin
      r_toCnt    <= '0;
      r_scanLost <= 1'b0;
    end else begin
      if (r_toCnt != TIMEOUT_VAL)
        r_toCnt <= r_toCnt + 32'd1;
      if (w_toHit)
        r_scanLost <= 1'b1;
    end
  end

  assign o_digits    = r_digits;
  assign o_dp        = r_dp;
  assign o_frame_vld = r_frameVld;
  assign o_err       = r_err;
  assign o_scan_lost = r_scanLost;

endmodule

// File: tb/tb_seg_scan_rx.sv
// Self-checking bench for seg_scan_rx: table-driven frame scans plus hand-written glitch, error, timeout and reset sequences.
// Expected frames go into a queue when a scan is driven and are compared when o_frame_vld pulses.
`timescale 1ns/1ps
module tb_seg_scan_rx;

  localparam logic [6:0] S0 = 7'h7E;
  localparam logic [6:0] S1 = 7'h30;
  localparam logic [6:0] S2 = 7'h6D;
  localparam logic [6:0] S3 = 7'h79;
  localparam logic [6:0] S4 = 7'h33;
  localparam logic [6:0] S5 = 7'h5B;
  localparam logic [6:0] S6 = 7'h5F;
  localparam logic [6:0] S7 = 7'h70;
  localparam logic [6:0] S8 = 7'h7F;
  localparam logic [6:0] S9 = 7'h73;
  localparam logic [6:0] SB = 7'h00;
  localparam logic [6:0] SX = 7'h01;
  localparam int         DWELL = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  i_seg_enb;
  logic [6:0]  i_seg;
  logic        i_seg_dp;
  logic        i_clr;
  logic [23:0] o_digits;
  logic [5:0]  o_dp;
  logic        o_frame_vld;
  logic        o_err;
  logic        o_scan_lost;

  int          checks = 0;
  int          failures = 0;
  int          framesSeen = 0;
  logic [29:0] expQ[$];
  logic [29:0] expFrame;

  typedef struct {
    logic [5:0][6:0] seg;
    logic [5:0]      dp;
    logic [23:0]     expDigits;
    logic [5:0]      expDp;
    logic            expErr;
  } vec_t;

  vec_t vecs[4];

  seg_scan_rx #(
    .STABLE_CNT (4),
    .TIMEOUT    (200)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_seg_enb   (i_seg_enb),
    .i_seg       (i_seg),
    .i_seg_dp    (i_seg_dp),
    .i_clr       (i_clr),
    .o_digits    (o_digits),
    .o_dp        (o_dp),
    .o_frame_vld (o_frame_vld),
    .o_err       (o_err),
    .o_scan_lost (o_scan_lost)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] enb, input logic [6:0] seg, input logic dp, input int n);
    i_seg_enb = enb;
    i_seg     = seg;
    i_seg_dp  = dp;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scanDigits(input logic [5:0][6:0] seg, input logic [5:0] dp, input int first, input int last);
    logic [5:0] enb;
    for (int k = first; k <= last; k++) begin
      enb = 6'b000001 << k;
      enb = ~enb;
      applyStimulus(enb, seg[k], dp[k], DWELL);
    end
  endtask

  task automatic pulseClear();
    i_clr = 1'b1;
    @(posedge clk);
    #1;
    i_clr = 1'b0;
  endtask

  // Frame scoreboard: every published frame must match the oldest expected one.
  always @(negedge clk) begin
    if (o_frame_vld === 1'b1) begin
      framesSeen++;
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_frame: got digits 0x%06h dp 0x%02h expected no frame", o_digits, o_dp);
      end else begin
        expFrame = expQ.pop_front();
        checkOutput("frame_digits", 32'(o_digits), 32'(expFrame[29:6]));
        checkOutput("frame_dp", 32'(o_dp), 32'(expFrame[5:0]));
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no end of test expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0][6:0] segA;
    logic [5:0][6:0] segB;
    int f0;

    vecs[0].seg = {SB, SB, S1, S2, S3, S4};
    vecs[0].dp = 6'h00; vecs[0].expDigits = 24'hFF1234; vecs[0].expDp = 6'h00; vecs[0].expErr = 1'b0;
    vecs[1].seg = {S0, S5, S6, S7, S8, S9};
    vecs[1].dp = 6'h05; vecs[1].expDigits = 24'h056789; vecs[1].expDp = 6'h05; vecs[1].expErr = 1'b0;
    vecs[2].seg = {S7, SB, S4, S2, S0, S2};
    vecs[2].dp = 6'h20; vecs[2].expDigits = 24'h7F4202; vecs[2].expDp = 6'h20; vecs[2].expErr = 1'b0;
    vecs[3].seg = {S1, S1, S1, SX, S1, S1};
    vecs[3].dp = 6'h12; vecs[3].expDigits = 24'h111E11; vecs[3].expDp = 6'h12; vecs[3].expErr = 1'b1;

    rst = 1'b1;
    i_clr = 1'b0;
    applyStimulus(6'h3F, SB, 1'b0, 3);
    checkOutput("reset_digits", 32'(o_digits), 32'h00FFFFFF);
    checkOutput("reset_dp", 32'(o_dp), 32'd0);
    checkOutput("reset_vld", 32'(o_frame_vld), 32'd0);
    checkOutput("reset_err", 32'(o_err), 32'd0);
    checkOutput("reset_lost", 32'(o_scan_lost), 32'd0);
    rst = 1'b0;
    applyStimulus(6'h3F, SB, 1'b0, 4);

    for (int i = 0; i < 4; i++) begin
      expQ.push_back({vecs[i].expDigits, vecs[i].expDp});
      scanDigits(vecs[i].seg, vecs[i].dp, 0, 5);
      checkOutput("table_err", 32'(o_err), 32'(vecs[i].expErr));
      if (vecs[i].expErr) begin
        pulseClear();
        checkOutput("table_err_clr", 32'(o_err), 32'd0);
      end
    end

    // Glitch inside digit 0's dwell must neither latch nor flag an error.
    expQ.push_back({24'hFFFFF7, 6'h00});
    applyStimulus(6'b111110, S7, 1'b0, 2);
    applyStimulus(6'b111110, SX, 1'b0, 2);
    applyStimulus(6'b111110, S7, 1'b0, 6);
    segA = '0;
    scanDigits(segA, 6'h00, 1, 5);
    checkOutput("glitch_err", 32'(o_err), 32'd0);

    f0 = framesSeen;
    applyStimulus(6'b111100, S8, 1'b0, 10);
    checkOutput("multi_enb_err", 32'(o_err), 32'd1);
    checkOutput("multi_enb_no_frame", 32'(framesSeen), 32'(f0));
    applyStimulus(6'h3F, SB, 1'b0, 3);
    pulseClear();
    checkOutput("multi_enb_clr", 32'(o_err), 32'd0);

    // Scan stops after three digits long enough to trip the timeout.
    segA = {SB, SB, SB, S3, S2, S1};
    scanDigits(segA, 6'h00, 0, 2);
    checkOutput("lost_before", 32'(o_scan_lost), 32'd0);
    applyStimulus(6'h3F, SB, 1'b0, 250);
    checkOutput("lost_set", 32'(o_scan_lost), 32'd1);
    checkOutput("lost_digits_held", 32'(o_digits), 32'h00FFFFF7);
    checkOutput("lost_no_frame", 32'(framesSeen), 32'(f0));
    segB = {S8, S8, S8, S8, S8, S8};
    scanDigits(segB, 6'h3F, 3, 5);
    checkOutput("lost_cleared", 32'(o_scan_lost), 32'd0);
    checkOutput("resume_partial_no_frame", 32'(framesSeen), 32'(f0));
    expQ.push_back({24'h888888, 6'h3F});
    scanDigits(segB, 6'h3F, 0, 2);
    checkOutput("resume_err", 32'(o_err), 32'd0);

    // Reset after four latched digits drops the partial frame.
    segA = {S9, S9, SX, S3, S2, S1};
    scanDigits(segA, 6'h00, 0, 3);
    checkOutput("pre_reset_err", 32'(o_err), 32'd1);
    rst = 1'b1;
    #2;
    checkOutput("midreset_digits", 32'(o_digits), 32'h00FFFFFF);
    checkOutput("midreset_dp", 32'(o_dp), 32'd0);
    checkOutput("midreset_err", 32'(o_err), 32'd0);
    checkOutput("midreset_lost", 32'(o_scan_lost), 32'd0);
    applyStimulus(6'h3F, SB, 1'b0, 2);
    rst = 1'b0;
    applyStimulus(6'h3F, SB, 1'b0, 2);
    f0 = framesSeen;
    segB = {S9, S9, S4, S4, S4, S4};
    scanDigits(segB, 6'h00, 4, 5);
    checkOutput("post_reset_no_frame", 32'(framesSeen), 32'(f0));
    expQ.push_back({24'h994444, 6'h00});
    scanDigits(segB, 6'h00, 0, 3);
    checkOutput("post_reset_err", 32'(o_err), 32'd0);
    applyStimulus(6'h3F, SB, 1'b0, 4);

    checkOutput("frames_pending", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
